// File: rtl/hex_display_scanner.sv
// Four-digit time-multiplexed 7-segment scanner: two hex digits, a flags digit and a heartbeat
// digit, with per-slot anti-ghost blanking and per-frame input snapshots.
module hex_display_scanner #(
    parameter int OUTER_CLK_FRQ = 1000000,
    parameter int SCAN_FRQ      = 1000,
    parameter int BLANK_CYCLES  = 16,
    parameter int SEG_ACT_LOW   = 1,
    parameter int AN_ACT_LOW    = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic [6:0] lowerHex,
    input  logic [6:0] higherHex,
    input  logic [1:0] flags,
    output logic [6:0] seg,
    output logic       dp,
    output logic [3:0] an,
    output logic       frame_done
);

    localparam int DIV = OUTER_CLK_FRQ / SCAN_FRQ;
    localparam int CW  = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] CYC_LAST  = CW'(DIV - 1);
    localparam logic [CW-1:0] CYC_BLANK = CW'(BLANK_CYCLES);
    localparam logic [6:0] SEG_OFF = (SEG_ACT_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic       DP_OFF  = (SEG_ACT_LOW != 0) ? 1'b1 : 1'b0;
    localparam logic [3:0] AN_OFF  = (AN_ACT_LOW != 0) ? 4'hF : 4'h0;

    typedef enum logic [0:0] {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    state_t          state_r, state_nxt_s;
    logic [CW-1:0]   cyc_r, cyc_nxt_s;
    logic [1:0]      slot_r, slot_nxt_s;
    logic            frame_end_s;
    logic [6:0]      sh_low_r, sh_high_r;
    logic [1:0]      sh_flags_r;
    logic            heartbeat_r;
    logic [6:0]      seg_on_s;
    logic            dp_on_s;
    logic [3:0]      an_on_s;
    logic [6:0]      seg_nxt_s;
    logic            dp_nxt_s;
    logic [3:0]      an_nxt_s;

    // Map a logical "on" pattern to the physical drive level.
    function automatic logic [6:0] seg_drive(input logic [6:0] v);
        seg_drive = (SEG_ACT_LOW != 0) ? ~v : v;
    endfunction

    function automatic logic [3:0] an_drive(input logic [3:0] v);
        an_drive = (AN_ACT_LOW != 0) ? ~v : v;
    endfunction

    // Cycle/slot counter advance and end-of-frame detection.
    always_comb begin
        cyc_nxt_s   = cyc_r;
        slot_nxt_s  = slot_r;
        frame_end_s = 1'b0;
        if (enable) begin
            frame_end_s = (cyc_r == CYC_LAST) && (slot_r == 2'd3);
            if (cyc_r == CYC_LAST) begin
                cyc_nxt_s  = '0;
                slot_nxt_s = slot_r + 2'd1;
            end else begin
                cyc_nxt_s  = cyc_r + CW'(1);
                slot_nxt_s = slot_r;
            end
        end else begin
            cyc_nxt_s  = cyc_r;
            slot_nxt_s = slot_r;
        end
        state_nxt_s = (cyc_nxt_s < CYC_BLANK) ? ST_BLANK : ST_SHOW;
    end

    // Slot content decode and output pattern selection by FSM state.
    always_comb begin
        seg_on_s = 7'h00;
        dp_on_s  = 1'b0;
        an_on_s  = 4'b0001 << slot_r;
        case (slot_r)
            2'd0:    seg_on_s = sh_low_r;
            2'd1:    seg_on_s = sh_high_r;
            2'd2:    seg_on_s = {3'b000, sh_flags_r[0], 2'b00, sh_flags_r[1]};
            2'd3:    dp_on_s  = heartbeat_r;
            default: seg_on_s = 7'h00;
        endcase
        seg_nxt_s = SEG_OFF;
        dp_nxt_s  = DP_OFF;
        an_nxt_s  = AN_OFF;
        case (state_r)
            ST_BLANK: begin
                seg_nxt_s = SEG_OFF;
                dp_nxt_s  = DP_OFF;
                an_nxt_s  = AN_OFF;
            end
            ST_SHOW: begin
                seg_nxt_s = seg_drive(seg_on_s);
                dp_nxt_s  = (SEG_ACT_LOW != 0) ? ~dp_on_s : dp_on_s;
                an_nxt_s  = an_drive(an_on_s);
            end
            default: begin
                seg_nxt_s = SEG_OFF;
                dp_nxt_s  = DP_OFF;
                an_nxt_s  = AN_OFF;
            end
        endcase
    end

    // Scan counters, FSM state and frame snapshot registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc_r       <= '0;
            slot_r      <= 2'd0;
            state_r     <= ST_BLANK;
            sh_low_r    <= 7'h00;
            sh_high_r   <= 7'h00;
            sh_flags_r  <= 2'b00;
            heartbeat_r <= 1'b0;
        end else begin
            cyc_r   <= cyc_nxt_s;
            slot_r  <= slot_nxt_s;
            state_r <= state_nxt_s;
            if (frame_end_s) begin
                sh_low_r    <= lowerHex;
                sh_high_r   <= higherHex;
                sh_flags_r  <= flags;
                heartbeat_r <= ~heartbeat_r;
            end
        end
    end

    // Registered display drive; disabled scanning forces the display dark.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else if (!enable) begin
            seg        <= SEG_OFF;
            dp         <= DP_OFF;
            an         <= AN_OFF;
            frame_done <= 1'b0;
        end else begin
            seg        <= seg_nxt_s;
            dp         <= dp_nxt_s;
            an         <= an_nxt_s;
            frame_done <= frame_end_s;
        end
    end

endmodule

// File: tb/tb_hex_display_scanner.sv
// Directed bench for hex_display_scanner with DIV=8, BLANK_CYCLES=2, active-low outputs.
module tb_hex_display_scanner;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [6:0] lowerHex, higherHex;
    logic [1:0] flags;
    logic [6:0] seg;
    logic       dp;
    logic [3:0] an;
    logic       frame_done;

    int checks = 0;
    int errors = 0;

    hex_display_scanner #(
        .OUTER_CLK_FRQ(64), .SCAN_FRQ(8), .BLANK_CYCLES(2),
        .SEG_ACT_LOW(1), .AN_ACT_LOW(1)
    ) dut (
        .clk(clk), .reset(reset), .enable(enable),
        .lowerHex(lowerHex), .higherHex(higherHex), .flags(flags),
        .seg(seg), .dp(dp), .an(an), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         adv;
        logic       en;
        logic [6:0] lo;
        logic [6:0] hi;
        logic [1:0] fl;
        logic [6:0] seg;
        logic       dp;
        logic [3:0] an;
        logic       fd;
    } vec_t;

    vec_t tv[23];

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string tag, input logic [6:0] es, input logic ed,
                           input logic [3:0] ea, input logic ef);
        chk({tag, ".seg"}, {9'd0, seg}, {9'd0, es});
        chk({tag, ".dp"}, {15'd0, dp}, {15'd0, ed});
        chk({tag, ".an"}, {12'd0, an}, {12'd0, ea});
        chk({tag, ".frame_done"}, {15'd0, frame_done}, {15'd0, ef});
    endtask

    initial begin
        int fd_cnt;
        int blank_cnt;
        int bad_an;
        bit found;

        // frame 0 shows zeros, frame 1 shows 3F/06/flags, lowerHex changes mid-frame 1,
        // then enable is dropped for 10 clk during slot1 SHOW of frame 2
        tv[0]  = '{1, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[1]  = '{1, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[2]  = '{1, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hE, 1'b0};
        tv[3]  = '{5, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hE, 1'b0};
        tv[4]  = '{1, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[5]  = '{2, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hD, 1'b0};
        tv[6]  = '{8, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hB, 1'b0};
        tv[7]  = '{8, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'h7, 1'b0};
        tv[8]  = '{5, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'h7, 1'b1};
        tv[9]  = '{1, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[10] = '{2, 1'b1, 7'h3F, 7'h06, 2'b10, 7'h40, 1'b1, 4'hE, 1'b0};
        tv[11] = '{8, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h79, 1'b1, 4'hD, 1'b0};
        tv[12] = '{8, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h7E, 1'b1, 4'hB, 1'b0};
        tv[13] = '{8, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h7F, 1'b0, 4'h7, 1'b0};
        tv[14] = '{5, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h7F, 1'b0, 4'h7, 1'b1};
        tv[15] = '{3, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h24, 1'b1, 4'hE, 1'b0};
        tv[16] = '{8, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h79, 1'b1, 4'hD, 1'b0};
        tv[17] = '{1, 1'b0, 7'h5B, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[18] = '{9, 1'b0, 7'h5B, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[19] = '{1, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h79, 1'b1, 4'hD, 1'b0};
        tv[20] = '{4, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h79, 1'b1, 4'hD, 1'b0};
        tv[21] = '{1, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h7F, 1'b1, 4'hF, 1'b0};
        tv[22] = '{2, 1'b1, 7'h5B, 7'h06, 2'b10, 7'h7E, 1'b1, 4'hB, 1'b0};

        reset     = 1'b1;
        enable    = 1'b1;
        lowerHex  = 7'h3F;
        higherHex = 7'h06;
        flags     = 2'b10;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk_all($sformatf("reset%0d", i), 7'h7F, 1'b1, 4'hF, 1'b0);
        end
        reset = 1'b0;

        for (int i = 0; i < 23; i++) begin
            enable    = tv[i].en;
            lowerHex  = tv[i].lo;
            higherHex = tv[i].hi;
            flags     = tv[i].fl;
            repeat (tv[i].adv) @(negedge clk);
            chk_all($sformatf("vec%0d", i), tv[i].seg, tv[i].dp, tv[i].an, tv[i].fd);
        end

        // any 64-cycle window: two frame_done pulses, 16 blanked samples, anodes one-hot or dark
        fd_cnt = 0;
        blank_cnt = 0;
        bad_an = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (frame_done) fd_cnt++;
            if (an == 4'hF) blank_cnt++;
            else if (an != 4'hE && an != 4'hD && an != 4'hB && an != 4'h7) bad_an++;
        end
        chk("frame_done_per_64", 16'(fd_cnt), 16'd2);
        chk("blank_per_64", 16'(blank_cnt), 16'd16);
        chk("an_onehot", 16'(bad_an), 16'd0);

        // asynchronous reset in the middle of a slot2 SHOW
        found = 1'b0;
        for (int i = 0; i < 64 && !found; i++) begin
            @(negedge clk);
            if (an == 4'hB) found = 1'b1;
        end
        if (!found) begin
            checks++;
            errors++;
            $display("FAIL slot2_wait: an never reached 4'hB within 64 clk");
        end
        #2 reset = 1'b1;
        #1;
        chk_all("async_reset", 7'h7F, 1'b1, 4'hF, 1'b0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk_all("post_reset_blank", 7'h7F, 1'b1, 4'hF, 1'b0);
        repeat (2) @(negedge clk);
        chk_all("post_reset_slot0", 7'h7F, 1'b1, 4'hE, 1'b0);
        repeat (24) @(negedge clk);
        chk_all("post_reset_slot3", 7'h7F, 1'b1, 4'h7, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
